// File: rtl/jogador_automatico.sv
// Automatic player for the memory game: records each LED the game lights and,
// when the game asks for a play, replays the recorded sequence on the buttons.
module jogador_automatico #(
    parameter int PROFUNDIDADE = 16,
    parameter int T_PRESS      = 100,
    parameter int T_SOLTA      = 100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic [3:0] leds,
    input  logic       espera_jogada,
    input  logic       fim_jogo,
    input  logic       errar,
    output logic [3:0] botoes,
    output logic       ocupado,
    output logic       erro,
    output logic [4:0] num_jogadas,
    output logic [2:0] db_estado
);

    localparam int T_MAX = (T_PRESS > T_SOLTA) ? T_PRESS : T_SOLTA;
    localparam int CW    = $clog2(T_MAX + 1);
    localparam int AW    = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;

    localparam logic [4:0]    PROF      = 5'(PROFUNDIDADE);
    localparam logic [CW-1:0] CNT_PRESS = CW'(T_PRESS);
    localparam logic [CW-1:0] CNT_SOLTA = CW'(T_SOLTA);
    localparam logic [CW-1:0] CNT_UM    = CW'(1);

    typedef enum logic [2:0] {
        INATIVO   = 3'd0,
        CAPTURA   = 3'd1,
        PRESSIONA = 3'd2,
        SOLTA     = 3'd3,
        FIM       = 3'd4
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [4:0]    num_q, num_d;
    logic [4:0]    rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          erro_q, erro_d;
    logic [3:0]    botoes_q, botoes_d;
    logic [3:0]    leds_ant_q;
    logic          espera_ant_q;

    logic [3:0]    mem_q [PROFUNDIDADE];
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [3:0]    rd_dado;

    logic          led_borda;
    logic          led_onehot;
    logic          espera_sobe;

    assign led_borda   = (leds_ant_q == 4'b0000) && (leds != 4'b0000);
    assign led_onehot  = ((leds & (leds - 4'd1)) == 4'b0000);
    assign espera_sobe = espera_jogada && !espera_ant_q;

    always_comb begin
        estado_d = estado_q;
        num_d    = num_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        erro_d   = erro_q;
        wr_en    = 1'b0;
        wr_addr  = num_q[AW-1:0];

        if (estado_q != INATIVO && !habilita) begin
            estado_d = INATIVO;
        end else if (estado_q != INATIVO && fim_jogo) begin
            estado_d = FIM;
        end else begin
            case (estado_q)
                INATIVO: begin
                    if (habilita) begin
                        estado_d = CAPTURA;
                        erro_d   = 1'b0;
                    end
                end
                CAPTURA: begin
                    if (led_borda) begin
                        if (led_onehot && num_q < PROF) begin
                            wr_en = 1'b1;
                            num_d = num_q + 5'd1;
                        end else begin
                            erro_d = 1'b1;
                        end
                    end
                    // num_d already includes an LED captured this same cycle
                    if (espera_sobe) begin
                        if (num_d != 5'd0) begin
                            rd_d     = 5'd0;
                            cnt_d    = CNT_PRESS;
                            estado_d = PRESSIONA;
                        end else begin
                            erro_d = 1'b1;
                        end
                    end
                end
                PRESSIONA: begin
                    if (cnt_q == CNT_UM) begin
                        cnt_d    = CNT_SOLTA;
                        estado_d = SOLTA;
                    end else begin
                        cnt_d = cnt_q - CNT_UM;
                    end
                end
                SOLTA: begin
                    if (cnt_q == CNT_UM) begin
                        if (rd_q == num_q - 5'd1) begin
                            num_d    = 5'd0;
                            estado_d = CAPTURA;
                        end else begin
                            rd_d     = rd_q + 5'd1;
                            cnt_d    = CNT_PRESS;
                            estado_d = PRESSIONA;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_UM;
                    end
                end
                FIM: begin
                    estado_d = FIM;
                end
                default: begin
                    estado_d = INATIVO;
                end
            endcase
        end

        if (estado_d == INATIVO) begin
            num_d = 5'd0;
        end
    end

    // Forward the entry being written so a same-cycle capture and replay start agree.
    always_comb begin
        if (wr_en && (wr_addr == rd_d[AW-1:0])) begin
            rd_dado = leds;
        end else begin
            rd_dado = mem_q[rd_d[AW-1:0]];
        end

        botoes_d = 4'b0000;
        if (estado_d == PRESSIONA) begin
            botoes_d = rd_dado;
            if (errar && (rd_d == num_d - 5'd1)) begin
                botoes_d = {rd_dado[2:0], rd_dado[3]};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q     <= INATIVO;
            num_q        <= 5'd0;
            rd_q         <= 5'd0;
            cnt_q        <= '0;
            erro_q       <= 1'b0;
            botoes_q     <= 4'b0000;
            leds_ant_q   <= 4'b0000;
            espera_ant_q <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            num_q        <= num_d;
            rd_q         <= rd_d;
            cnt_q        <= cnt_d;
            erro_q       <= erro_d;
            botoes_q     <= botoes_d;
            leds_ant_q   <= leds;
            espera_ant_q <= espera_jogada;
        end
    end

    // Sequence storage is left unreset; only the pointers are cleared.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= leds;
        end
    end

    assign botoes      = botoes_q;
    assign ocupado     = (estado_q == PRESSIONA) || (estado_q == SOLTA);
    assign erro        = erro_q;
    assign num_jogadas = num_q;
    assign db_estado   = estado_q;

endmodule
